// File: rtl/dual_port_ecc_bank_memory.sv
// dual_port_ecc_bank_memory: single-clock true dual-port banked memory with SECDED ECC
//
// Build option: define DPM_ECC_EN to compile in the SECDED encoder/decoder and the
// error flags. Without it the array stores raw data, i_flip[WIDTH-1:0] XORs the raw
// word, and o_sbe/o_dbe/o_corr_cnt read as 0. Latencies are identical in both builds.
//
// Ports (X = a or b):
//   i_clk, i_rst         shared clock, synchronous active-high reset
//   i_en_X, i_we_X       request strobe, write(1)/read(0) select
//   i_addr_X, i_din_X    word address, write data
//   i_flip_X             XOR mask applied to the stored word on write (error injection)
//   o_dout_X, o_valid_X  corrected read data, one-cycle valid per read
//   o_sbe_X, o_dbe_X     single-bit corrected / double-bit detected
//   o_collision          both ports committed a write to one address on the previous edge
//   o_corr_cnt           saturating count of single-bit corrections

module dpm_ecc_port #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int CODE_WIDTH    = 13,
    parameter int WORD_WIDTH    = 13,
    parameter int WRITE_LATENCY = 1,
    parameter int READ_LATENCY  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_din,
    input  logic [CODE_WIDTH-1:0] i_flip,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [WORD_WIDTH-1:0] o_wr_word,
    output logic                  o_rd_en,
    input  logic [WORD_WIDTH-1:0] i_rd_word,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_valid,
    output logic                  o_sbe,
    output logic                  o_dbe
);
    logic                  w_wr_req;
    logic                  w_rd_req;
    logic [WORD_WIDTH-1:0] w_wr_word;
    logic [WIDTH-1:0]      w_dec_data;
    logic                  w_dec_sbe;
    logic                  w_dec_dbe;
    logic                  r_raw_vld;
    logic [WIDTH-1:0]      w_st_data;
    logic                  w_st_sbe;
    logic                  w_st_dbe;

    // A request sampled while reset is high is ignored.
    assign w_wr_req = i_en && i_we && !i_rst;
    assign w_rd_req = i_en && !i_we && !i_rst;
    assign o_rd_en  = w_rd_req;

`ifdef DPM_ECC_EN
    localparam int PAR_BITS = CODE_WIDTH - WIDTH - 1;

    // Data fills non-power-of-two positions 3,5,6,7,9...; bit 0 is overall parity.
    function automatic logic [CODE_WIDTH-1:0] f_encode(input logic [WIDTH-1:0] d);
        logic [CODE_WIDTH-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p < CODE_WIDTH; p++)
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        for (int i = 0; i < PAR_BITS; i++)
            for (int p = 1; p < CODE_WIDTH; p++)
                if (p[i] && p != (1 << i)) c[1 << i] ^= c[p];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [PAR_BITS-1:0] f_syndrome(input logic [CODE_WIDTH-1:0] c);
        logic [PAR_BITS-1:0] s;
        s = '0;
        for (int i = 0; i < PAR_BITS; i++)
            for (int p = 1; p < CODE_WIDTH; p++)
                if (p[i]) s[i] ^= c[p];
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] f_extract(input logic [CODE_WIDTH-1:0] c);
        logic [WIDTH-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < CODE_WIDTH; p++)
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p];
                j++;
            end
        return d;
    endfunction

    logic [PAR_BITS-1:0]   w_syn;
    logic                  w_par_bad;
    logic [CODE_WIDTH-1:0] w_fixed;

    assign w_wr_word = f_encode(i_din) ^ i_flip;
    assign w_syn     = f_syndrome(i_rd_word);
    assign w_par_bad = ^i_rd_word;

    // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself.
    always_comb begin
        w_fixed = i_rd_word;
        if (w_par_bad && 32'(w_syn) < CODE_WIDTH) w_fixed[w_syn] = ~i_rd_word[w_syn];
    end

    assign w_dec_data = f_extract(w_fixed);
    assign w_dec_sbe  = w_par_bad;
    assign w_dec_dbe  = !w_par_bad && (w_syn != '0);
`else
    logic w_unused_flip;

    assign w_unused_flip = ^i_flip[CODE_WIDTH-1:WIDTH];
    assign w_wr_word     = i_din ^ i_flip[WIDTH-1:0];
    assign w_dec_data    = i_rd_word;
    assign w_dec_sbe     = 1'b0;
    assign w_dec_dbe     = 1'b0;
`endif

    // Write pipeline: latency 1 commits straight from the sampling edge.
    generate
        if (WRITE_LATENCY == 1) begin : g_wr_direct
            assign o_wr_en   = w_wr_req;
            assign o_wr_addr = i_addr;
            assign o_wr_word = w_wr_word;
        end else begin : g_wr_pipe
            logic [WRITE_LATENCY-2:0] r_v;
            logic [ADDR_WIDTH-1:0]    r_a [WRITE_LATENCY-1];
            logic [WORD_WIDTH-1:0]    r_d [WRITE_LATENCY-1];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_v <= '0;
                end else begin
                    r_v[0] <= w_wr_req;
                    for (int i = 1; i < WRITE_LATENCY - 1; i++) r_v[i] <= r_v[i-1];
                end
                r_a[0] <= i_addr;
                r_d[0] <= w_wr_word;
                for (int i = 1; i < WRITE_LATENCY - 1; i++) begin
                    r_a[i] <= r_a[i-1];
                    r_d[i] <= r_d[i-1];
                end
            end

            // Gated by reset so an in-flight write is dropped rather than committed.
            assign o_wr_en   = r_v[WRITE_LATENCY-2] && !i_rst;
            assign o_wr_addr = r_a[WRITE_LATENCY-2];
            assign o_wr_word = r_d[WRITE_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) r_raw_vld <= 1'b0;
        else r_raw_vld <= w_rd_req;
    end

    // Decoded results are zeroed outside valid so every stage downstream stays clean.
    assign w_st_data = r_raw_vld ? w_dec_data : '0;
    assign w_st_sbe  = r_raw_vld && w_dec_sbe;
    assign w_st_dbe  = r_raw_vld && w_dec_dbe;

    generate
        if (READ_LATENCY == 1) begin : g_rd_direct
            assign o_valid = r_raw_vld;
            assign o_dout  = w_st_data;
            assign o_sbe   = w_st_sbe;
            assign o_dbe   = w_st_dbe;
        end else begin : g_rd_pipe
            logic [READ_LATENCY-2:0] r_v;
            logic [READ_LATENCY-2:0] r_s;
            logic [READ_LATENCY-2:0] r_e;
            logic [WIDTH-1:0]        r_d [READ_LATENCY-1];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_v <= '0;
                    r_s <= '0;
                    r_e <= '0;
                    for (int i = 0; i < READ_LATENCY - 1; i++) r_d[i] <= '0;
                end else begin
                    r_v[0] <= r_raw_vld;
                    r_s[0] <= w_st_sbe;
                    r_e[0] <= w_st_dbe;
                    r_d[0] <= w_st_data;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_s[i] <= r_s[i-1];
                        r_e[i] <= r_e[i-1];
                        r_d[i] <= r_d[i-1];
                    end
                end
            end

            assign o_valid = r_v[READ_LATENCY-2];
            assign o_sbe   = r_s[READ_LATENCY-2];
            assign o_dbe   = r_e[READ_LATENCY-2];
            assign o_dout  = r_d[READ_LATENCY-2];
        end
    endgenerate
endmodule

module dual_port_ecc_bank_memory #(
    parameter int WIDTH           = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int NUM_BANK        = 4,
    parameter int WRITE_LATENCY_A = 1,
    parameter int WRITE_LATENCY_B = 1,
    parameter int READ_LATENCY_A  = 2,
    parameter int READ_LATENCY_B  = 2,
    parameter int CODE_WIDTH      = WIDTH + $clog2(WIDTH + $clog2(WIDTH + 1) + 1) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en_a,
    input  logic                  i_en_b,
    input  logic                  i_we_a,
    input  logic                  i_we_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [WIDTH-1:0]      i_din_a,
    input  logic [WIDTH-1:0]      i_din_b,
    input  logic [CODE_WIDTH-1:0] i_flip_a,
    input  logic [CODE_WIDTH-1:0] i_flip_b,
    output logic [WIDTH-1:0]      o_dout_a,
    output logic [WIDTH-1:0]      o_dout_b,
    output logic                  o_valid_a,
    output logic                  o_valid_b,
    output logic                  o_sbe_a,
    output logic                  o_sbe_b,
    output logic                  o_dbe_a,
    output logic                  o_dbe_b,
    output logic                  o_collision,
    output logic [7:0]            o_corr_cnt
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int BANK_DEPTH = DEPTH / NUM_BANK;
    localparam int BANK_LOG   = $clog2(NUM_BANK);
    localparam int BW         = (BANK_LOG > 0) ? BANK_LOG : 1;
    localparam int OW         = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
`ifdef DPM_ECC_EN
    localparam int WORD_WIDTH = CODE_WIDTH;
`else
    localparam int WORD_WIDTH = WIDTH;
`endif

    // Bank comes from the top address bits, the in-bank offset from the rest.
    function automatic logic [BW-1:0] f_bank(input logic [ADDR_WIDTH-1:0] a);
        return BW'(a >> (ADDR_WIDTH - BANK_LOG));
    endfunction

    function automatic logic [OW-1:0] f_off(input logic [ADDR_WIDTH-1:0] a);
        return OW'(a & ADDR_WIDTH'(BANK_DEPTH - 1));
    endfunction

    logic                  w_wr_en_a;
    logic                  w_wr_en_b;
    logic [ADDR_WIDTH-1:0] w_wr_addr_a;
    logic [ADDR_WIDTH-1:0] w_wr_addr_b;
    logic [WORD_WIDTH-1:0] w_wr_word_a;
    logic [WORD_WIDTH-1:0] w_wr_word_b;
    logic                  w_rd_en_a;
    logic                  w_rd_en_b;
    logic [WORD_WIDTH-1:0] w_q_a [NUM_BANK];
    logic [WORD_WIDTH-1:0] w_q_b [NUM_BANK];
    logic [BW-1:0]         r_rbank_a;
    logic [BW-1:0]         r_rbank_b;
    logic                  r_collision;

    dpm_ecc_port #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CODE_WIDTH(CODE_WIDTH),
        .WORD_WIDTH(WORD_WIDTH), .WRITE_LATENCY(WRITE_LATENCY_A), .READ_LATENCY(READ_LATENCY_A)
    ) u_port_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en_a), .i_we(i_we_a), .i_addr(i_addr_a),
        .i_din(i_din_a), .i_flip(i_flip_a), .o_wr_en(w_wr_en_a), .o_wr_addr(w_wr_addr_a),
        .o_wr_word(w_wr_word_a), .o_rd_en(w_rd_en_a), .i_rd_word(w_q_a[r_rbank_a]),
        .o_dout(o_dout_a), .o_valid(o_valid_a), .o_sbe(o_sbe_a), .o_dbe(o_dbe_a)
    );

    dpm_ecc_port #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CODE_WIDTH(CODE_WIDTH),
        .WORD_WIDTH(WORD_WIDTH), .WRITE_LATENCY(WRITE_LATENCY_B), .READ_LATENCY(READ_LATENCY_B)
    ) u_port_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en_b), .i_we(i_we_b), .i_addr(i_addr_b),
        .i_din(i_din_b), .i_flip(i_flip_b), .o_wr_en(w_wr_en_b), .o_wr_addr(w_wr_addr_b),
        .o_wr_word(w_wr_word_b), .o_rd_en(w_rd_en_b), .i_rd_word(w_q_b[r_rbank_b]),
        .o_dout(o_dout_b), .o_valid(o_valid_b), .o_sbe(o_sbe_b), .o_dbe(o_dbe_b)
    );

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
            logic [WORD_WIDTH-1:0] r_mem [BANK_DEPTH];
            logic [WORD_WIDTH-1:0] r_q_a;
            logic [WORD_WIDTH-1:0] r_q_b;
            logic                  w_we_a;
            logic                  w_we_b;
            logic                  w_re_a;
            logic                  w_re_b;

            assign w_we_a = w_wr_en_a && (f_bank(w_wr_addr_a) == BW'(b));
            assign w_we_b = w_wr_en_b && (f_bank(w_wr_addr_b) == BW'(b));
            assign w_re_a = w_rd_en_a && (f_bank(i_addr_a) == BW'(b));
            assign w_re_b = w_rd_en_b && (f_bank(i_addr_b) == BW'(b));

            // Port A is written last so it wins a same-address collision; reads are read-first.
            always_ff @(posedge i_clk) begin
                if (w_we_b) r_mem[f_off(w_wr_addr_b)] <= w_wr_word_b;
                if (w_we_a) r_mem[f_off(w_wr_addr_a)] <= w_wr_word_a;
                if (w_re_a) r_q_a <= r_mem[f_off(i_addr_a)];
                if (w_re_b) r_q_b <= r_mem[f_off(i_addr_b)];
            end

            assign w_q_a[b] = r_q_a;
            assign w_q_b[b] = r_q_b;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_rd_en_a) r_rbank_a <= f_bank(i_addr_a);
        if (w_rd_en_b) r_rbank_b <= f_bank(i_addr_b);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_collision <= 1'b0;
        else r_collision <= w_wr_en_a && w_wr_en_b && (w_wr_addr_a == w_wr_addr_b);
    end

    assign o_collision = r_collision;

`ifdef DPM_ECC_EN
    logic [7:0] r_corr_cnt;
    logic [8:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_corr_cnt} + 9'(o_sbe_a) + 9'(o_sbe_b);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_corr_cnt <= '0;
        else r_corr_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    end

    assign o_corr_cnt = r_corr_cnt;
`else
    assign o_corr_cnt = '0;
`endif
endmodule

// File: tb/tb_dual_port_ecc_bank_memory.sv
// tb_dual_port_ecc_bank_memory: directed self-checking bench for dual_port_ecc_bank_memory
module tb_dual_port_ecc_bank_memory;
`ifdef DPM_ECC_EN
    localparam bit ECC = 1'b1;
`else
    localparam bit ECC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [7:0]  din_a, din_b;
    logic [12:0] flip_a, flip_b;
    logic [7:0]  dout_a, dout_b;
    logic        valid_a, valid_b, sbe_a, sbe_b, dbe_a, dbe_b, collision;
    logic [7:0]  corr_cnt;

    logic        rst4, en4, we4;
    logic [4:0]  addr4;
    logic [7:0]  din4;
    logic [7:0]  dout4, dout4_b;
    logic        valid4, valid4_b, sbe4, sbe4_b, dbe4, dbe4_b, collision4;
    logic [7:0]  corr_cnt4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_port_ecc_bank_memory u_dut (
        .i_clk(clk), .i_rst(rst), .i_en_a(en_a), .i_en_b(en_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_din_a(din_a), .i_din_b(din_b),
        .i_flip_a(flip_a), .i_flip_b(flip_b), .o_dout_a(dout_a), .o_dout_b(dout_b),
        .o_valid_a(valid_a), .o_valid_b(valid_b), .o_sbe_a(sbe_a), .o_sbe_b(sbe_b),
        .o_dbe_a(dbe_a), .o_dbe_b(dbe_b), .o_collision(collision), .o_corr_cnt(corr_cnt)
    );

    dual_port_ecc_bank_memory #(.WRITE_LATENCY_A(4), .WRITE_LATENCY_B(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en_a(en4), .i_en_b(1'b0), .i_we_a(we4), .i_we_b(1'b0),
        .i_addr_a(addr4), .i_addr_b(5'd0), .i_din_a(din4), .i_din_b(8'd0),
        .i_flip_a(13'd0), .i_flip_b(13'd0), .o_dout_a(dout4), .o_dout_b(dout4_b),
        .o_valid_a(valid4), .o_valid_b(valid4_b), .o_sbe_a(sbe4), .o_sbe_b(sbe4_b),
        .o_dbe_a(dbe4), .o_dbe_b(dbe4_b), .o_collision(collision4), .o_corr_cnt(corr_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic en, input logic we, input logic [4:0] a,
                         input logic [7:0] d, input logic [12:0] f);
        en_a = en; we_a = we; addr_a = a; din_a = d; flip_a = f;
    endtask

    task automatic drv_b(input logic en, input logic we, input logic [4:0] a,
                         input logic [7:0] d, input logic [12:0] f);
        en_b = en; we_b = we; addr_b = a; din_b = d; flip_b = f;
    endtask

    task automatic drv4(input logic en, input logic we, input logic [4:0] a, input logic [7:0] d);
        en4 = en; we4 = we; addr4 = a; din4 = d;
    endtask

    task automatic idle();
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        rst4 = 1'b1;
        idle();
        drv4(0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_flags", {valid_a, valid_b, sbe_a, sbe_b, dbe_a, dbe_b, collision}, 0);
        chk("rst_dout", {dout_a, dout_b}, 0);
        chk("rst_cnt", corr_cnt, 0);
        rst = 1'b0;
        rst4 = 1'b0;

        // Write A then read B, latency 2, single-cycle valid
        drv_a(1, 1, 3, 8'hA5, 0); tick();
        drv_a(0, 0, 0, 0, 0); drv_b(1, 0, 3, 0, 0); tick();
        idle();
        chk("t1_not_yet", valid_b, 0);
        tick();
        chk("t1_valid", valid_b, 1);
        chk("t1_dout", dout_b, 8'hA5);
        chk("t1_flags", {sbe_b, dbe_b}, 0);
        tick();
        chk("t1_one_cycle", valid_b, 0);
        chk("t1_dout_zero", dout_b, 0);

        // Single-bit injection on a Hamming parity position
        drv_a(1, 1, 7, 8'h3C, 13'h0004); tick();
        drv_a(1, 0, 7, 0, 0); tick();
        idle(); tick();
        chk("sbe_valid", valid_a, 1);
        chk("sbe_dout", dout_a, ECC ? 8'h3C : 8'h38);
        chk("sbe_flags", {sbe_a, dbe_a}, ECC ? 2'b10 : 2'b00);
        chk("sbe_cnt_before", corr_cnt, 0);
        tick();
        chk("sbe_cnt_after", corr_cnt, ECC ? 1 : 0);

        // Double-bit injection on B
        drv_b(1, 1, 12, 8'h5A, 13'h0003); tick();
        drv_b(1, 0, 12, 0, 0); tick();
        idle(); tick();
        chk("dbe_dout", dout_b, ECC ? 8'h5A : 8'h59);
        chk("dbe_flags", {sbe_b, dbe_b}, ECC ? 2'b01 : 2'b00);
        tick();
        chk("dbe_cnt", corr_cnt, ECC ? 1 : 0);

        // Flip of the overall parity bit
        drv_b(1, 1, 5, 8'h10, 13'h0001); tick();
        drv_b(1, 0, 5, 0, 0); tick();
        idle(); tick();
        chk("par_dout", dout_b, ECC ? 8'h10 : 8'h11);
        chk("par_flags", {sbe_b, dbe_b}, ECC ? 2'b10 : 2'b00);
        tick();
        chk("par_cnt", corr_cnt, ECC ? 2 : 0);

        // Collision: A wins; different addresses do not collide
        drv_a(1, 1, 9, 8'h11, 0); drv_b(1, 1, 9, 8'h22, 0); tick();
        chk("col_hi", collision, 1);
        drv_a(1, 1, 10, 8'h44, 0); drv_b(1, 1, 11, 8'h66, 0); tick();
        chk("col_lo", collision, 0);
        drv_a(1, 0, 9, 0, 0); drv_b(1, 0, 11, 0, 0); tick();
        idle(); tick();
        chk("col_data_a", dout_a, 8'h11);
        chk("col_data_b", dout_b, 8'h66);

        // One word per bank, back-to-back reads
        for (int i = 0; i < 4; i++) begin
            drv_a(1, 1, 5'(i * 8), 8'(8'hC0 + i), 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drv_a(1, 0, 5'(i * 8), 0, 0);
            else drv_a(0, 0, 0, 0, 0);
            if (i == 2) drv_b(1, 0, 16, 0, 0);
            else drv_b(0, 0, 0, 0, 0);
            tick();
            if (i == 0) chk("bank_lat", valid_a, 0);
            else begin
                chk("bank_valid", valid_a, 1);
                chk("bank_dout", dout_a, 8'hC0 + i - 1);
            end
            if (i == 3) chk("bank_same_b", dout_b, 8'hC2);
        end
        tick();
        chk("bank_end", valid_a, 0);

        // Read-first: a same-edge write is not visible
        drv_a(1, 1, 0, 8'h77, 0); drv_b(1, 0, 0, 0, 0); tick();
        idle(); tick();
        chk("rf_old", dout_b, 8'hC0);
        drv_b(1, 0, 0, 0, 0); tick();
        idle(); tick();
        chk("rf_new", dout_b, 8'h77);

        // Saturating counter: both ports read the corrected word every cycle
        drv_a(1, 0, 7, 0, 0); drv_b(1, 0, 7, 0, 0);
        repeat (130) tick();
        idle();
        repeat (3) tick();
        chk("cnt_sat", corr_cnt, ECC ? 8'hFF : 8'h00);

        // Reset mid-read; write sampled during reset ignored
        drv_a(1, 0, 3, 0, 0); tick();
        rst = 1'b1; drv_a(1, 1, 3, 8'h99, 0); tick();
        chk("mid_rst_flags", {valid_a, valid_b, sbe_a, sbe_b, dbe_a, dbe_b, collision}, 0);
        chk("mid_rst_dout", {dout_a, dout_b}, 0);
        chk("mid_rst_cnt", corr_cnt, 0);
        rst = 1'b0; idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_novalid", valid_a, 0);
        end
        drv_a(1, 0, 3, 0, 0); tick();
        idle(); tick();
        chk("mid_rst_keep", dout_a, 8'hA5);

        // WL=4: no forwarding, read-first at commit edge
        drv4(1, 1, 0, 8'hC0); tick();
        drv4(1, 1, 1, 8'h31); tick();
        drv4(0, 0, 0, 0);
        repeat (4) tick();
        drv4(1, 1, 0, 8'hEE); tick();
        drv4(0, 0, 0, 0); tick();
        drv4(1, 0, 0, 0); tick();
        drv4(1, 0, 0, 0); tick();
        chk("wl4_valid", valid4, 1);
        chk("wl4_old", dout4, 8'hC0);
        drv4(1, 0, 0, 0); tick();
        chk("wl4_commit_edge", dout4, 8'hC0);
        drv4(0, 0, 0, 0); tick();
        chk("wl4_new", dout4, 8'hEE);

        // WL=4: reset drops an in-flight write
        drv4(1, 1, 1, 8'h55); tick();
        drv4(0, 0, 0, 0); rst4 = 1'b1; tick();
        rst4 = 1'b0;
        repeat (4) tick();
        drv4(1, 0, 1, 0); tick();
        drv4(0, 0, 0, 0); tick();
        chk("wl4_drop", dout4, 8'h31);
        chk("wl4_flags", {sbe4, dbe4, collision4}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
